// File: rtl/id_branch_fwd_ctrl.sv
// ID-stage branch-compare forwarding control: shadow scoreboard of the EX, MEM
// and WB destinations, RD1/RD2 forward selects, load-use stall and stall counter.
module id_branch_fwd_ctrl #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              ld;
  } slot_t;

  slot_t             ex_q, mem_q, wb_q, ex_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [2:0]        res_a, res_b;
  logic              stall_c;

  function automatic logic match(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wr && (s.dst == r) && (r != '0);
  endfunction

  // Returns {hazard, select}. The youngest matching slot decides alone, so an
  // ALU write in EX hides an older load to the same register.
  function automatic logic [2:0] resolve(input logic use_f, input logic [REG_AW-1:0] r,
                                         input logic br, input slot_t ex_s,
                                         input slot_t mem_s, input slot_t wb_s);
    logic [2:0] res;
    res = 3'b000;
    if (use_f) begin
      if (match(ex_s, r))       res = ex_s.ld  ? 3'b100 : 3'b001;
      else if (match(mem_s, r)) res = mem_s.ld ? {br, 2'b00} : 3'b010;
      else if (match(wb_s, r))  res = 3'b011;
    end
    return res;
  endfunction

  always_comb begin
    res_a   = resolve(id_use_rs, id_rs, id_is_branch, ex_q, mem_q, wb_q);
    res_b   = resolve(id_use_rt, id_rt, id_is_branch, ex_q, mem_q, wb_q);
    stall_c = id_valid && !flush && (res_a[2] || res_b[2]);
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (id_valid && id_is_branch && !stall_c) begin
      fwd_a_sel = res_a[1:0];
      fwd_b_sel = res_b[1:0];
    end
  end

  always_comb begin
    ex_d.valid  = id_valid && !flush && !stall_c && id_reg_write && (id_dst != '0);
    ex_d.dst    = id_dst;
    ex_d.wr     = id_reg_write;
    ex_d.ld     = id_mem_read;
    stall_cnt_d = stall_cnt_q;
    if (stall_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall     = stall_c;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_branch_fwd_ctrl.sv
// Bench for id_branch_fwd_ctrl: directed vector table, async reset mid-stall,
// then random traffic against a pipeline-history reference model.
module tb_id_branch_fwd_ctrl;

  logic       clk, rst;
  logic       id_valid, id_is_branch, id_use_rs, id_use_rt;
  logic [2:0] id_rs, id_rt, id_dst;
  logic       id_reg_write, id_mem_read, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel_s, fwd_b_sel_s;
  logic       stall, stall_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  id_branch_fwd_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy on the same inputs so saturation is reached quickly.
  id_branch_fwd_ctrl #(.REG_AW(3), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a_sel(fwd_a_sel_s), .fwd_b_sel(fwd_b_sel_s),
    .stall(stall_s), .stall_cnt(stall_cnt_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, br, urs, urt;
    logic [2:0] rs, rt, dst;
    logic rw, mr, fl;
    logic [1:0] ea, eb;
    logic es;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  // reference model: history of issued instructions, index 0 = youngest (EX)
  logic       hv[3], hw[3], hl[3];
  logic [2:0] hd[3];
  int         m_cnt;
  logic [1:0] m_a, m_b;
  logic       m_st;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void operand(input logic use_f, input logic [2:0] r,
                                  output logic [1:0] sel, output logic haz);
    logic found;
    sel = 2'b00; haz = 1'b0; found = 1'b0;
    if (use_f && r != 3'd0) begin
      for (int d = 0; d < 3; d++) begin
        if (!found && hv[d] && hw[d] && hd[d] == r) begin
          found = 1'b1;
          // distance from ID decides which path can deliver the value
          if (d == 0) begin if (hl[d]) haz = 1'b1; else sel = 2'b01; end
          else if (d == 1) begin if (hl[d]) haz = id_is_branch; else sel = 2'b10; end
          else sel = 2'b11;
        end
      end
    end
  endfunction

  function automatic void model_eval();
    logic [1:0] sa, sb;
    logic ha, hb;
    operand(id_use_rs, id_rs, sa, ha);
    operand(id_use_rt, id_rt, sb, hb);
    m_st = id_valid && !flush && (ha || hb);
    m_a  = (id_valid && id_is_branch && !m_st) ? sa : 2'b00;
    m_b  = (id_valid && id_is_branch && !m_st) ? sb : 2'b00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin hv[i] = 0; hw[i] = 0; hl[i] = 0; hd[i] = 0; end
    m_cnt = 0;
  endtask

  task automatic model_clock();
    if (rst) model_clear();
    else begin
      for (int i = 2; i > 0; i--) begin
        hv[i] = hv[i-1]; hw[i] = hw[i-1]; hl[i] = hl[i-1]; hd[i] = hd[i-1];
      end
      hv[0] = id_valid && !flush && !m_st && id_reg_write && id_dst != 3'd0;
      hw[0] = id_reg_write; hl[0] = id_mem_read; hd[0] = id_dst;
      if (m_st) m_cnt++;
    end
  endtask

  task automatic check_model();
    model_eval();
    chk("fwd_a_sel", {14'd0, fwd_a_sel}, {14'd0, m_a});
    chk("fwd_b_sel", {14'd0, fwd_b_sel}, {14'd0, m_b});
    chk("stall", {15'd0, stall}, {15'd0, m_st});
    chk("stall_cnt", stall_cnt, (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0]);
    chk("stall_cnt_narrow", {12'd0, stall_cnt_s}, (m_cnt > 15) ? 16'd15 : m_cnt[15:0]);
  endtask

  // driver
  task automatic drive(input vec_t t);
    id_valid = t.v; id_is_branch = t.br; id_use_rs = t.urs; id_use_rt = t.urt;
    id_rs = t.rs; id_rt = t.rt; id_dst = t.dst;
    id_reg_write = t.rw; id_mem_read = t.mr; flush = t.fl;
  endtask

  task automatic step(input vec_t t, input logic chk_tab, input int idx);
    drive(t);
    #1;
    check_model();
    if (chk_tab) begin
      chk($sformatf("tab%0d_a", idx), {14'd0, fwd_a_sel}, {14'd0, t.ea});
      chk($sformatf("tab%0d_b", idx), {14'd0, fwd_b_sel}, {14'd0, t.eb});
      chk($sformatf("tab%0d_stall", idx), {15'd0, stall}, {15'd0, t.es});
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic v, br, urs, urt, input logic [2:0] rs, rt, dst,
                              input logic rw, mr, fl, input logic [1:0] ea, eb, input logic es);
    vec_t t;
    t.v = v; t.br = br; t.urs = urs; t.urt = urt; t.rs = rs; t.rt = rt; t.dst = dst;
    t.rw = rw; t.mr = mr; t.fl = fl; t.ea = ea; t.eb = eb; t.es = es;
    return t;
  endfunction

  vec_t tab[21];
  vec_t nop, tmp;

  initial begin
    nop = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
    tab[0]  = mk(1,0,1,1, 1,2,3, 1,0,0, 0,0,0); // ADD r3
    tab[1]  = mk(1,1,1,1, 3,4,0, 0,0,0, 1,0,0); // BEQ r3,r4: ALU forward
    tab[2]  = mk(1,0,0,0, 0,0,2, 1,0,0, 0,0,0); // ADD r2
    tab[3]  = nop;
    tab[4]  = mk(1,1,1,1, 5,2,0, 0,0,0, 0,2,0); // BEQ r5,r2: EX/MEM forward
    tab[5]  = mk(1,0,0,0, 0,0,1, 1,1,0, 0,0,0); // LW r1
    tab[6]  = mk(1,1,1,1, 1,0,0, 0,0,0, 0,0,1); // BEQ r1,r0 stall 1
    tab[7]  = mk(1,1,1,1, 1,0,0, 0,0,0, 0,0,1); // stall 2
    tab[8]  = mk(1,1,1,1, 1,0,0, 0,0,0, 3,0,0); // WB forward
    tab[9]  = mk(1,0,0,0, 0,0,1, 1,1,0, 0,0,0); // LW r1
    tab[10] = nop;
    tab[11] = mk(1,0,0,0, 0,0,1, 1,0,0, 0,0,0); // ADD r1
    tab[12] = mk(1,1,1,1, 1,0,0, 0,0,0, 1,0,0); // EX ADD beats WB LW
    tab[13] = mk(1,0,0,0, 0,0,6, 1,1,0, 0,0,0); // LW r6
    tab[14] = mk(1,0,1,0, 6,0,7, 1,0,0, 0,0,1); // ADD r7,r6: one stall
    tab[15] = mk(1,0,1,0, 6,0,7, 1,0,0, 0,0,0);
    tab[16] = mk(1,0,0,0, 0,0,0, 1,0,0, 0,0,0); // ADD r0
    tab[17] = mk(1,1,1,0, 0,7,0, 0,0,0, 0,0,0); // r0 and unused rt: nothing
    tab[18] = mk(1,0,0,0, 0,0,2, 1,1,0, 0,0,0); // LW r2
    tab[19] = mk(1,0,1,0, 2,0,3, 1,0,1, 0,0,0); // hazard under flush
    tab[20] = mk(1,1,1,0, 3,0,0, 0,0,0, 0,0,0); // flushed ADD r3 left no trace

    drive(nop);
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("rst_b", {14'd0, fwd_b_sel}, 16'd0);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) step(tab[i], 1'b1, i);
    chk("directed_cnt", stall_cnt, 16'd3);

    // async reset in the middle of a load-use branch stall
    step(mk(1,0,0,0, 0,0,1, 1,1,0, 0,0,0), 1'b0, 0);
    tmp = mk(1,1,1,1, 1,0,0, 0,0,0, 0,0,1);
    drive(tmp);
    #1;
    chk("pre_rst_stall", {15'd0, stall}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_stall", {15'd0, stall}, 16'd0);
    chk("midrst_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("midrst_b", {14'd0, fwd_b_sel}, 16'd0);
    chk("midrst_cnt", stall_cnt, 16'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(tmp, 1'b0, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tmp.v   = ($urandom_range(0, 9) != 0);
      tmp.br  = ($urandom_range(0, 9) < 4);
      tmp.urs = ($urandom_range(0, 3) != 0);
      tmp.urt = ($urandom_range(0, 3) != 0);
      tmp.rs  = 3'($urandom_range(0, 3));
      tmp.rt  = 3'($urandom_range(0, 3));
      tmp.dst = 3'($urandom_range(0, 3));
      tmp.mr  = ($urandom_range(0, 2) == 0);
      tmp.rw  = tmp.mr || ($urandom_range(0, 3) != 0);
      tmp.fl  = ($urandom_range(0, 9) == 0);
      step(tmp, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
